// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: fetch handshake, control-flow overrides and BTB update port.
// master is the PC generator; slave is the pipeline/instruction-memory side.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_pred_taken;
  logic            btb_upd_valid;
  logic [XLEN-1:0] btb_upd_pc;
  logic [XLEN-1:0] btb_upd_target;
  logic            btb_upd_taken;

  modport master (
    input  stall, redirect_valid, redirect_pc, trap_valid, trap_pc,
    input  fetch_ready,
    input  btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
    output fetch_valid, fetch_pc, fetch_pred_taken
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, trap_valid, trap_pc,
    output fetch_ready,
    output btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
    input  fetch_valid, fetch_pc, fetch_pred_taken
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with trap/redirect/stall priority and a
// direct-mapped branch target buffer predicting taken branches in the same cycle.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     BTB_ENTRIES  = 8
) (
  input  logic      clk,
  input  logic      rst,
  pc_gen_if.master  bus
);

  localparam int unsigned     IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned     TAG_W = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  // Each BTB entry carries even parity over tag and target; a corrupted entry reads as a miss.
  function automatic logic entry_parity(input logic [TAG_W-1:0] tag, input logic [XLEN-3:0] tgt);
    return ^{tag, tgt};
  endfunction

  state_e          state_r;
  state_e          state_next_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic            fetch_valid_s;
  logic            accept_s;

  logic             btb_valid_r [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_r   [BTB_ENTRIES];
  logic [XLEN-3:0]  btb_tgt_r   [BTB_ENTRIES];
  logic             btb_par_r   [BTB_ENTRIES];

  logic [IDX-1:0]   look_idx_s;
  logic [TAG_W-1:0] look_tag_s;
  logic             look_par_ok_s;
  logic             hit_s;
  logic [XLEN-1:0]  hit_target_s;

  logic [IDX-1:0]   upd_idx_s;
  logic [TAG_W-1:0] upd_tag_s;
  logic [XLEN-3:0]  upd_tgt_s;
  logic             upd_tag_match_s;
  logic             unused_bits_s;

  assign look_idx_s    = pc_r[IDX+1:2];
  assign look_tag_s    = pc_r[XLEN-1:IDX+2];
  assign look_par_ok_s = (btb_par_r[look_idx_s] == entry_parity(btb_tag_r[look_idx_s], btb_tgt_r[look_idx_s]));
  assign hit_s         = btb_valid_r[look_idx_s] & (btb_tag_r[look_idx_s] == look_tag_s) & look_par_ok_s;
  assign hit_target_s  = {btb_tgt_r[look_idx_s], 2'b00};

  assign upd_idx_s       = bus.btb_upd_pc[IDX+1:2];
  assign upd_tag_s       = bus.btb_upd_pc[XLEN-1:IDX+2];
  assign upd_tgt_s       = bus.btb_upd_target[XLEN-1:2];
  assign upd_tag_match_s = (btb_tag_r[upd_idx_s] == upd_tag_s);
  assign unused_bits_s   = ^{bus.btb_upd_pc[1:0], bus.btb_upd_target[1:0]};

  assign accept_s = fetch_valid_s & bus.fetch_ready & ~bus.stall;

  assign bus.fetch_valid      = fetch_valid_s;
  assign bus.fetch_pc         = pc_r;
  assign bus.fetch_pred_taken = hit_s;

  // Request-valid state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: one idle cycle out of reset, then requests are continuous.
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: state_next_s = ST_RUN;
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode of the request state.
  always_comb begin
    fetch_valid_s = 1'b0;
    case (state_r)
      ST_RUN:  fetch_valid_s = 1'b1;
      default: fetch_valid_s = 1'b0;
    endcase
  end

  // Next-PC selection; trap and redirect override stall and backpressure.
  always_comb begin
    pc_next_s = pc_r;
    if (bus.trap_valid) begin
      pc_next_s = word_align(bus.trap_pc);
    end else if (bus.redirect_valid) begin
      pc_next_s = word_align(bus.redirect_pc);
    end else if (!accept_s) begin
      pc_next_s = pc_r;
    end else if (hit_s) begin
      pc_next_s = hit_target_s;
    end else begin
      pc_next_s = pc_r + INC_W;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_VECTOR;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // BTB storage; lookup reads these registers, so a same-cycle update is seen one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        btb_valid_r[i] <= 1'b0;
        btb_tag_r[i]   <= '0;
        btb_tgt_r[i]   <= '0;
        btb_par_r[i]   <= 1'b0;
      end
    end else if (bus.btb_upd_valid) begin
      if (bus.btb_upd_taken) begin
        btb_valid_r[upd_idx_s] <= 1'b1;
        btb_tag_r[upd_idx_s]   <= upd_tag_s;
        btb_tgt_r[upd_idx_s]   <= upd_tgt_s;
        btb_par_r[upd_idx_s]   <= entry_parity(upd_tag_s, upd_tgt_s);
      end else if (upd_tag_match_s) begin
        btb_valid_r[upd_idx_s] <= 1'b0;
      end else begin
        btb_valid_r[upd_idx_s] <= btb_valid_r[upd_idx_s];
      end
    end
  end

endmodule
